front_panel_input: RTL and testbench

FRONT_PANEL_INPUT -- requirements
Module: front_panel_input

---
 rtl/front_panel_input.sv | 210 +++++++++++++++++++++
 tb/tb_front_panel_input.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/front_panel_input.sv
// Front-panel input conditioning: synchronised, debounced pushbuttons with press/release/chord pulses and a debounced DIP-switch vector.
// Optional auto-repeat of held buttons is built only when the AUTOREPEAT_EN macro is defined.
module front_panel_input #(
    parameter int DEBOUNCE_TICKS = 499999,
    parameter int REPEAT_DELAY   = 24999999,
    parameter int REPEAT_RATE    = 9999999
) (
    input  logic       M_CLOCK,
    input  logic       M_RESET,
    input  logic [3:0] IO_PB,
    input  logic [7:0] IO_DSW,
    output logic [3:0] PB_LEVEL,
    output logic [3:0] PB_PRESS,
    output logic [3:0] PB_RELEASE,
    output logic       CHORD_SET,
    output logic [7:0] DSW_VAL,
    output logic       DSW_CHANGE
);

    localparam int CNT_W = (DEBOUNCE_TICKS > 0) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_TICKS);
    // The sample that opens a wait state already counts as one stable cycle.
    localparam logic [CNT_W-1:0] CNT_FIRST = (DEBOUNCE_TICKS > 0) ? CNT_W'(1) : '0;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } pbState_t;

    logic [3:0] pbMeta, pbSync;
    logic [7:0] dswMeta, dswSync;

    pbState_t         state     [4];
    pbState_t         stateNext [4];
    logic [CNT_W-1:0] cnt       [4];
    logic [CNT_W-1:0] cntNext   [4];
    logic [3:0]       acceptPress, acceptRelease;
    logic [3:0]       pressNext;
    logic             chordPrev;

    logic [7:0]       dswSample;
    logic [CNT_W-1:0] dswCnt;

    always_ff @(posedge M_CLOCK) begin
        if (M_RESET) begin
            pbMeta  <= '0;
            pbSync  <= '0;
            dswMeta <= '0;
            dswSync <= '0;
        end else begin
            pbMeta  <= IO_PB;
            pbSync  <= pbMeta;
            dswMeta <= IO_DSW;
            dswSync <= dswMeta;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stateNext[i]     = state[i];
            cntNext[i]       = cnt[i];
            acceptPress[i]   = 1'b0;
            acceptRelease[i] = 1'b0;
            case (state[i])
                RELEASED: begin
                    if (pbSync[i]) begin
                        stateNext[i] = PRESS_WAIT;
                        cntNext[i]   = CNT_FIRST;
                    end
                end
                PRESS_WAIT: begin
                    if (!pbSync[i]) begin
                        stateNext[i] = RELEASED;
                        cntNext[i]   = '0;
                    end else if (cnt[i] == CNT_TERM) begin
                        stateNext[i]   = HELD;
                        cntNext[i]     = '0;
                        acceptPress[i] = 1'b1;
                    end else begin
                        cntNext[i] = cnt[i] + 1'b1;
                    end
                end
                HELD: begin
                    if (!pbSync[i]) begin
                        stateNext[i] = RELEASE_WAIT;
                        cntNext[i]   = CNT_FIRST;
                    end
                end
                RELEASE_WAIT: begin
                    if (pbSync[i]) begin
                        stateNext[i] = HELD;
                        cntNext[i]   = '0;
                    end else if (cnt[i] == CNT_TERM) begin
                        stateNext[i]     = RELEASED;
                        cntNext[i]       = '0;
                        acceptRelease[i] = 1'b1;
                    end else begin
                        cntNext[i] = cnt[i] + 1'b1;
                    end
                end
                default: begin
                    stateNext[i] = RELEASED;
                    cntNext[i]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            PB_LEVEL[i] = (state[i] == HELD) || (state[i] == RELEASE_WAIT);
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = (RPT_MAX > 0) ? $clog2(RPT_MAX + 1) : 1;
    localparam logic [RPT_W-1:0] RPT_FIRST_TERM = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_NEXT_TERM  = RPT_W'(REPEAT_RATE);

    logic [RPT_W-1:0] rptCnt     [4];
    logic [RPT_W-1:0] rptCntNext [4];
    logic [3:0]       rptFirst, rptFirstNext;
    logic [3:0]       repeatPulse;
    logic             chordHeld;

    // Repeats only advance while the button is settled in HELD; a chord mutes buttons 0 and 3.
    always_comb begin
        chordHeld = PB_LEVEL[0] & PB_LEVEL[3];
        for (int i = 0; i < 4; i++) begin
            rptCntNext[i]   = rptCnt[i];
            rptFirstNext[i] = rptFirst[i];
            repeatPulse[i]  = 1'b0;
            if (acceptPress[i]) begin
                rptCntNext[i]   = '0;
                rptFirstNext[i] = 1'b1;
            end else if (state[i] == HELD && pbSync[i]) begin
                if (rptCnt[i] == (rptFirst[i] ? RPT_FIRST_TERM : RPT_NEXT_TERM)) begin
                    rptCntNext[i]   = '0;
                    rptFirstNext[i] = 1'b0;
                    repeatPulse[i]  = !(chordHeld && (i == 0 || i == 3));
                end else begin
                    rptCntNext[i] = rptCnt[i] + 1'b1;
                end
            end
        end
        pressNext = acceptPress | repeatPulse;
    end

    always_ff @(posedge M_CLOCK) begin
        if (M_RESET) begin
            for (int i = 0; i < 4; i++) rptCnt[i] <= '0;
            rptFirst <= '0;
        end else begin
            for (int i = 0; i < 4; i++) rptCnt[i] <= rptCntNext[i];
            rptFirst <= rptFirstNext;
        end
    end
`else
    always_comb begin
        pressNext = acceptPress;
    end
`endif

    always_ff @(posedge M_CLOCK) begin
        if (M_RESET) begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= RELEASED;
                cnt[i]   <= '0;
            end
            PB_PRESS   <= '0;
            PB_RELEASE <= '0;
            chordPrev  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= stateNext[i];
                cnt[i]   <= cntNext[i];
            end
            PB_PRESS   <= pressNext;
            PB_RELEASE <= acceptRelease;
            chordPrev  <= PB_LEVEL[0] & PB_LEVEL[3];
        end
    end

    assign CHORD_SET = PB_LEVEL[0] & PB_LEVEL[3] & ~chordPrev;

    // Any movement of the synced vector restarts the shared stability count.
    always_ff @(posedge M_CLOCK) begin
        if (M_RESET) begin
            dswSample  <= '0;
            dswCnt     <= '0;
            DSW_VAL    <= '0;
            DSW_CHANGE <= 1'b0;
        end else begin
            DSW_CHANGE <= 1'b0;
            if (dswSync != dswSample) begin
                dswSample <= dswSync;
                dswCnt    <= CNT_FIRST;
            end else if (dswCnt != CNT_TERM) begin
                dswCnt <= dswCnt + 1'b1;
            end else if (dswSample != DSW_VAL) begin
                DSW_VAL    <= dswSample;
                DSW_CHANGE <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_front_panel_input.sv
// Scoreboard bench for front_panel_input: expected pulse events are queued at drive time and matched cycle by cycle.
// Define AUTOREPEAT_EN for both files to exercise the auto-repeat build.
module tb_front_panel_input;

    localparam int DT  = 3;
    localparam int RD  = 10;
    localparam int RR  = 4;
    localparam int LAT = DT + 3;

    logic       M_CLOCK = 1'b0;
    logic       M_RESET;
    logic [3:0] IO_PB;
    logic [7:0] IO_DSW;
    logic [3:0] PB_LEVEL, PB_PRESS, PB_RELEASE;
    logic       CHORD_SET;
    logic [7:0] DSW_VAL;
    logic       DSW_CHANGE;

    front_panel_input #(
        .DEBOUNCE_TICKS(DT),
        .REPEAT_DELAY  (RD),
        .REPEAT_RATE   (RR)
    ) dut (
        .M_CLOCK   (M_CLOCK),
        .M_RESET   (M_RESET),
        .IO_PB     (IO_PB),
        .IO_DSW    (IO_DSW),
        .PB_LEVEL  (PB_LEVEL),
        .PB_PRESS  (PB_PRESS),
        .PB_RELEASE(PB_RELEASE),
        .CHORD_SET (CHORD_SET),
        .DSW_VAL   (DSW_VAL),
        .DSW_CHANGE(DSW_CHANGE)
    );

    always #5 M_CLOCK = ~M_CLOCK;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic       chord;
        logic       dswChg;
        logic [3:0] level;
        logic [7:0] dswVal;
    } event_t;

    event_t sbQ[$];
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    bit     monitorOn = 1'b0;

    always @(posedge M_CLOCK) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic expectEvent(input int at, input logic [3:0] press, input logic [3:0] rel,
                               input logic chord, input logic dswChg,
                               input logic [3:0] level, input logic [7:0] dswVal);
        event_t ev;
        ev.cyc = at; ev.press = press; ev.rel = rel; ev.chord = chord;
        ev.dswChg = dswChg; ev.level = level; ev.dswVal = dswVal;
        sbQ.push_back(ev);
    endtask

    task automatic applyStimulus(input logic [3:0] pb, input logic [7:0] dsw);
        IO_PB  = pb;
        IO_DSW = dsw;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge M_CLOCK);
        #1;
    endtask

    // Every cycle: retire overdue events, match the event due now, or flag any stray pulse.
    always @(negedge M_CLOCK) begin
        event_t ev;
        logic   anyPulse;
        if (monitorOn) begin
            anyPulse = (PB_PRESS != 4'd0) || (PB_RELEASE != 4'd0) || CHORD_SET || DSW_CHANGE;
            while (sbQ.size() > 0 && sbQ[0].cyc < cyc) begin
                ev = sbQ.pop_front();
                checkOutput("missedEventCycle", cyc, ev.cyc);
            end
            if (sbQ.size() > 0 && sbQ[0].cyc == cyc) begin
                ev = sbQ.pop_front();
                checkOutput("press",     PB_PRESS,   ev.press);
                checkOutput("release",   PB_RELEASE, ev.rel);
                checkOutput("chord",     CHORD_SET,  ev.chord);
                checkOutput("dswChange", DSW_CHANGE, ev.dswChg);
                checkOutput("level",     PB_LEVEL,   ev.level);
                checkOutput("dswVal",    DSW_VAL,    ev.dswVal);
            end else if (anyPulse) begin
                checkOutput("unexpectedPulse", {PB_PRESS, PB_RELEASE, CHORD_SET, DSW_CHANGE}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0, c1, hold;
        applyStimulus(4'h0, 8'h00);
        M_RESET = 1'b1;
        waitCycles(3);
        checkOutput("resetLevel",     PB_LEVEL,   4'h0);
        checkOutput("resetPress",     PB_PRESS,   4'h0);
        checkOutput("resetRelease",   PB_RELEASE, 4'h0);
        checkOutput("resetChord",     CHORD_SET,  1'b0);
        checkOutput("resetDswVal",    DSW_VAL,    8'h00);
        checkOutput("resetDswChange", DSW_CHANGE, 1'b0);
        M_RESET = 1'b0;
        monitorOn = 1'b1;
        waitCycles(5);

        $display("[TB] button 1 single press and release");
        c0 = cyc;
        applyStimulus(4'b0010, 8'h00);
        expectEvent(c0 + LAT, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, 8'h00);
        waitCycles(8);
        c1 = cyc;
        applyStimulus(4'b0000, 8'h00);
        expectEvent(c1 + LAT, 4'b0000, 4'b0010, 1'b0, 1'b0, 4'b0000, 8'h00);
        waitCycles(12);

        $display("[TB] button 2 short glitches");
        applyStimulus(4'b0100, 8'h00); waitCycles(2);
        applyStimulus(4'b0000, 8'h00); waitCycles(2);
        applyStimulus(4'b0100, 8'h00); waitCycles(2);
        applyStimulus(4'b0000, 8'h00); waitCycles(10);
        checkOutput("glitchLevel", PB_LEVEL, 4'h0);

        $display("[TB] chord on buttons 0 and 3");
        c0 = cyc;
        applyStimulus(4'b1001, 8'h00);
        expectEvent(c0 + LAT, 4'b1001, 4'b0000, 1'b1, 1'b0, 4'b1001, 8'h00);
        waitCycles(30);
        c1 = cyc;
        applyStimulus(4'b0000, 8'h00);
        expectEvent(c1 + LAT, 4'b0000, 4'b1001, 1'b0, 1'b0, 4'b0000, 8'h00);
        waitCycles(12);

        $display("[TB] button 1 long hold");
        hold = 41;
        c0 = cyc;
        applyStimulus(4'b0010, 8'h00);
        expectEvent(c0 + LAT, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, 8'h00);
`ifdef AUTOREPEAT_EN
        // Held state persists until the dropped input has crossed the two sync flops.
        for (int t = c0 + LAT + RD + 1; t <= c0 + hold + 2; t += RR + 1)
            expectEvent(t, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, 8'h00);
`endif
        waitCycles(hold);
        c1 = cyc;
        applyStimulus(4'b0000, 8'h00);
        expectEvent(c1 + LAT, 4'b0000, 4'b0010, 1'b0, 1'b0, 4'b0000, 8'h00);
        waitCycles(12);

        $display("[TB] switch change with bounce on bit 3");
        applyStimulus(4'b0000, 8'h5A); waitCycles(1);
        applyStimulus(4'b0000, 8'h52); waitCycles(1);
        c0 = cyc;
        applyStimulus(4'b0000, 8'h5A);
        expectEvent(c0 + LAT, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 8'h5A);
        waitCycles(12);
        checkOutput("dswSettled", DSW_VAL, 8'h5A);

        $display("[TB] reset while button 0 held");
        c0 = cyc;
        applyStimulus(4'b0001, 8'h5A);
        expectEvent(c0 + LAT, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 8'h5A);
        waitCycles(12);
        M_RESET = 1'b1;
        waitCycles(2);
        checkOutput("midResetLevel",   PB_LEVEL, 4'h0);
        checkOutput("midResetDswVal",  DSW_VAL,  8'h00);
        checkOutput("midResetRelease", PB_RELEASE, 4'h0);
        c1 = cyc;
        M_RESET = 1'b0;
        expectEvent(c1 + LAT, 4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0001, 8'h5A);
        waitCycles(10);
        c1 = cyc;
        applyStimulus(4'b0000, 8'h5A);
        expectEvent(c1 + LAT, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0000, 8'h5A);
        waitCycles(12);

        checkOutput("scoreboardDrained", sbQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
